// File: rtl/irq_ctrl_n_if.sv
// Register-bus and request/acknowledge signals shared by irq_ctrl_n and the core.
// The master drives writes, ack and EOI. The slave (the controller) returns read data and the request.
interface irq_ctrl_n_if #(
    parameter int VEC_WIDTH  = 3,
    parameter int DATA_WIDTH = 32
);
    logic                  i_we;
    logic [1:0]            i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_req;
    logic [VEC_WIDTH-1:0]  o_vec;
    logic                  i_ack;
    logic                  i_eoi;

    modport master (
        output i_we, i_addr, i_wdata, i_ack, i_eoi,
        input  o_rdata, o_req, o_vec
    );

    modport slave (
        input  i_we, i_addr, i_wdata, i_ack, i_eoi,
        output o_rdata, o_req, o_vec
    );
endinterface

// File: rtl/irq_ctrl_n.sv
// N-line interrupt controller with per-line edge/level mode and in-service nesting.
// It has an ack/EOI handshake and a four-register bank (CTRL, MASK, PEND, ISR).
module irq_ctrl_n #(
    parameter int                   IRQ_LINES  = 8,
    parameter int                   VEC_WIDTH  = 3,
    parameter int                   DATA_WIDTH = 32,
    parameter logic [IRQ_LINES-1:0] EDGE_MASK  = '1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [IRQ_LINES-1:0] i_irq,
    irq_ctrl_n_if.slave          bus
);

    typedef enum logic {ST_IDLE, ST_REQ} req_state_e;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_ISR  = 2'd3;

    logic [IRQ_LINES-1:0] sync1_q, sync1_d;
    logic [IRQ_LINES-1:0] sync2_q, sync2_d;
    logic [IRQ_LINES-1:0] prev_q,  prev_d;
    logic [IRQ_LINES-1:0] pend_q,  pend_d;
    logic [IRQ_LINES-1:0] mask_q,  mask_d;
    logic [IRQ_LINES-1:0] isr_q,   isr_d;
    logic                 gie_q,   gie_d;
    req_state_e           state_q, state_d;
    logic [VEC_WIDTH-1:0] vec_q,   vec_d;

    logic [IRQ_LINES-1:0] edge_det;
    logic [IRQ_LINES-1:0] pend_eff;
    logic [IRQ_LINES-1:0] cand_vec;
    logic [IRQ_LINES-1:0] vec_oh;
    logic [VEC_WIDTH-1:0] cand_idx;
    logic [VEC_WIDTH-1:0] isr_idx;
    logic                 cand_valid;
    logic                 cand_elig;
    logic                 frozen_elig;
    logic                 unused_wdata;

    // Upper write-data bits have no register behind them.
    assign unused_wdata = ^bus.i_wdata;

    function automatic logic [VEC_WIDTH-1:0] lowest_idx(input logic [IRQ_LINES-1:0] v);
        lowest_idx = '0;
        for (int i = IRQ_LINES - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = VEC_WIDTH'(i);
        end
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sync1_d  = i_irq;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        edge_det = sync2_q & ~prev_q;

        // Level-mode lines are not latched. They mirror the synchroniser every cycle.
        pend_eff   = (pend_q & EDGE_MASK) | (sync2_q & ~EDGE_MASK);
        cand_vec   = pend_eff & mask_q;
        cand_valid = |cand_vec;
        cand_idx   = lowest_idx(cand_vec);
        isr_idx    = lowest_idx(isr_q);

        cand_elig   = gie_q && cand_valid && ((isr_q == '0) || (cand_idx < isr_idx));
        frozen_elig = gie_q && pend_eff[vec_q] && mask_q[vec_q] &&
                      ((isr_q == '0) || (vec_q < isr_idx));

        vec_oh        = '0;
        vec_oh[vec_q] = 1'b1;

        gie_d   = gie_q;
        mask_d  = mask_q;
        pend_d  = pend_q;
        isr_d   = isr_q;
        state_d = state_q;
        vec_d   = vec_q;

        if (bus.i_we) begin
            case (bus.i_addr)
                ADDR_CTRL: gie_d  = bus.i_wdata[0];
                ADDR_MASK: mask_d = bus.i_wdata[IRQ_LINES-1:0];
                ADDR_PEND: pend_d = pend_q & ~bus.i_wdata[IRQ_LINES-1:0];
                default:   ;
            endcase
        end

        // EOI retires the old lowest bit before the ack sets the new one.
        if (bus.i_eoi && (isr_q != '0)) isr_d[isr_idx] = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cand_elig) begin
                    state_d = ST_REQ;
                    vec_d   = cand_idx;
                end
            end
            ST_REQ: begin
                if (bus.i_ack) begin
                    state_d = ST_IDLE;
                    isr_d   = isr_d | vec_oh;
                    pend_d  = pend_d & ~vec_oh;
                end else if (!frozen_elig) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh edge overrides both W1C and ack clears on the same cycle.
        pend_d = (pend_d | edge_det) & EDGE_MASK;

        bus.o_rdata = '0;
        case (bus.i_addr)
            ADDR_CTRL: bus.o_rdata = DATA_WIDTH'(gie_q);
            ADDR_MASK: bus.o_rdata = DATA_WIDTH'(mask_q);
            ADDR_PEND: bus.o_rdata = DATA_WIDTH'(pend_eff);
            ADDR_ISR:  bus.o_rdata = DATA_WIDTH'(isr_q);
            default:   bus.o_rdata = '0;
        endcase
    end

    assign bus.o_req = (state_q == ST_REQ);
    assign bus.o_vec = vec_q;

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            isr_q   <= '0;
            gie_q   <= 1'b0;
            state_q <= ST_IDLE;
            vec_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            isr_q   <= isr_d;
            gie_q   <= gie_d;
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

endmodule

// File: doc/irq_ctrl_n.md
Name: irq_ctrl_n

Overview:
- Parametrised N-line interrupt controller for the pipelined MIPS core.
- Successor to the fixed 4-line interrupt_control / priority-encoder / edge-detector group.
- Adds per-line edge or level mode, an in-service register for priority nesting, an ack/EOI handshake with the core, and a memory-mapped register bank on the data-memory bus.
- o_vec indexes the vector ROM that feeds the instruction-fetch mux.

Parameters:
- IRQ_LINES, 8: number of interrupt lines; legal range 2..32.
- VEC_WIDTH, 3: width of o_vec; must equal clog2(IRQ_LINES).
- DATA_WIDTH, 32: bus data width; must be ≥ IRQ_LINES.
- EDGE_MASK, all ones: per line, 1 = rising-edge mode, 0 = level mode.

Ports:
- i_clk, in, 1: core clock; all state is updated on its rising edge.
- i_rst, in, 1: reset. Synchronous, active-high.
- i_irq, in, IRQ_LINES: raw interrupt lines; asynchronous to i_clk.
- i_we, in, 1: register write strobe.
- i_addr, in, 2: register select.
- i_wdata, in, DATA_WIDTH: write data.
- o_rdata, out, DATA_WIDTH: read data; combinational from i_addr.
- o_req, out, 1: interrupt request to the core; registered.
- o_vec, out, VEC_WIDTH: index of the requesting line; registered.
- i_ack, in, 1: core accepts the current request.
- i_eoi, in, 1: end of interrupt; retires the highest-priority in-service line.

Behaviour:
- Reset (i_rst high at a clock edge): clears sync stages, edge history, CTRL, MASK, PEND, ISR, o_req and o_vec. o_rdata then reads 0 at every address.
- Register map (bits above IRQ_LINES read as 0; writes to them are ignored):
  - addr 0 CTRL: bit0 = GIE (global enable); read/write.
  - addr 1 MASK: per-line enable; read/write.
  - addr 2 PEND: read; writing 1 clears that edge-mode bit; level-mode bits ignore writes.
  - addr 3 ISR: read-only; writes are ignored.
- Input path: each i_irq bit goes through a 2-flop synchroniser, then an edge detector (sync2 & ~prev).
- Edge-mode pending timing: if i_irq first rises before edge E0, the PEND bit is set at edge E2.
- Level-mode PEND bit equals sync2 every cycle; it is not latched.
- Priority: lower index = higher priority.
- Candidate: lowest index with PEND & MASK set.
- Eligible when: GIE = 1, and ISR = 0 or the candidate index < lowest set ISR index.
- Request issue: when o_req is 0 and a candidate is eligible, o_req goes to 1 and o_vec to the candidate index at the next edge (edge E3 in the timing above).
- Request hold: while o_req = 1, o_vec is frozen, even if a higher-priority line arrives.
- Request withdraw: if the frozen line becomes ineligible (PEND cleared, MASK cleared, or GIE cleared), o_req drops at the next edge. Eligibility is then re-evaluated one cycle later.
- Ack:
  - i_ack with o_req = 1 at an edge sets ISR[o_vec], clears PEND[o_vec] (edge mode only) and clears o_req.
  - The next request can issue no earlier than the following edge.
  - i_ack with o_req = 0 is ignored.
- EOI: i_eoi clears the lowest set bit of the pre-edge ISR. It is ignored when ISR = 0.
- Simultaneous events:
  - i_ack and i_eoi on the same edge: EOI applies to the old ISR, then the ack bit is set. No conflict is possible, because an acked line always outranks all ISR bits.
  - New edge and W1C on the same PEND bit: the set wins.
  - New edge and ack on the same line: PEND stays 1.
  - Register write on the same edge as an ack: both take effect. CTRL/MASK writes affect eligibility from the next cycle.
- Nesting: a lower-or-equal priority line never requests while a higher line is in service. A higher line can request while a lower line is in service.
- Reset mid-request: o_req drops at the reset edge and all pending and in-service state is lost.

Test Plan:
- Single edge: GIE = 1, MASK = 0x04, pulse i_irq[2] for 1 cycle → PEND = 0x04 at edge E2, o_req = 1 and o_vec = 2 at E3. i_ack → ISR = 0x04, PEND = 0, o_req = 0. i_eoi → ISR = 0.
- Priority and freeze: MASK = 0xFF, raise lines 5 and 1 on the same cycle → o_vec = 1. Ack, then EOI → next request o_vec = 5. Raise line 0 while the line-5 request is pending and unacked → o_vec stays 5 until ack.
- Nesting: ISR = 0x08 (line 3 in service).
  - Pulse line 6 → no o_req.
  - Pulse line 1 → o_req with o_vec = 1; ack → ISR = 0x0A.
  - EOI → ISR = 0x08, and the pending line 6 is still blocked.
  - EOI → ISR = 0, then o_req with o_vec = 6.
- Level mode: EDGE_MASK = 0xFE, hold i_irq[0] high → PEND[0] follows; after ack and EOI, the line re-requests. Write PEND = 0x01 → no effect. Drop i_irq[0] before ack → o_req withdrawn.
- Races: W1C to PEND bit 4 on the same edge as a new line-4 edge → PEND[4] = 1. GIE = 0 while o_req = 1 → o_req = 0 next cycle.
- Reset mid-operation: o_req = 1 and ISR = 0x02, assert i_rst for one edge → o_req, o_vec, PEND, ISR, MASK and CTRL all read 0.
